// File: rtl/nand4_vector_sequencer.sv
// Stimulus/check stage for a 4-input NAND cell: sweeps all 16 {a,b,c,d}
// vectors, holds each for a settle window, then compares f_in against ~&vector.
module nand4_vector_sequencer #(
  parameter int HOLD_CYCLES = 10,
  parameter int ERR_W       = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             f_in,
  output logic             a,
  output logic             b,
  output logic             c,
  output logic             d,
  output logic [3:0]       vec_idx,
  output logic             busy,
  output logic             mismatch,
  output logic [ERR_W-1:0] err_count,
  output logic             done,
  output logic             pass
);

  typedef enum logic [1:0] {IDLE, SETTLE, CHECK, DONE} state_t;

  localparam logic [7:0] HOLD_LOAD = 8'(HOLD_CYCLES - 1);

  state_t           state, state_next;
  logic [7:0]       hold, hold_next;
  logic [3:0]       vec_next;
  logic [ERR_W-1:0] err_next, err_upd;
  logic             busy_next, mismatch_next, done_next, pass_next;
  logic             expected;
  logic [1:0]       rst_sync;
  logic             rst_int_n;

  // Reset asserts immediately but releases only on a clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync <= 2'b00;
    else        rst_sync <= {rst_sync[0], 1'b1};
  end

  assign rst_int_n = rst_sync[1];

  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      state     <= IDLE;
      hold      <= '0;
      vec_idx   <= '0;
      err_count <= '0;
      busy      <= 1'b0;
      mismatch  <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
    end else begin
      state     <= state_next;
      hold      <= hold_next;
      vec_idx   <= vec_next;
      err_count <= err_next;
      busy      <= busy_next;
      mismatch  <= mismatch_next;
      done      <= done_next;
      pass      <= pass_next;
    end
  end

  assign expected = ~(&vec_idx);

  always_comb begin
    state_next    = state;
    hold_next     = hold;
    vec_next      = vec_idx;
    err_next      = err_count;
    err_upd       = err_count;
    busy_next     = busy;
    mismatch_next = 1'b0;
    done_next     = done;
    pass_next     = pass;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          vec_next   = '0;
          err_next   = '0;
          done_next  = 1'b0;
          pass_next  = 1'b0;
          busy_next  = 1'b1;
          hold_next  = HOLD_LOAD;
          state_next = SETTLE;
        end
      end
      SETTLE: begin
        if (hold == 8'd0) state_next = CHECK;
        else              hold_next  = hold - 8'd1;
      end
      CHECK: begin
        // Counter saturates so a wide sweep can never wrap back to "pass".
        if (f_in != expected) begin
          mismatch_next = 1'b1;
          if (err_count != '1) err_upd = err_count + 1'b1;
        end
        err_next = err_upd;
        if (vec_idx == 4'hF) begin
          state_next = DONE;
          busy_next  = 1'b0;
          done_next  = 1'b1;
          pass_next  = (err_upd == '0);
        end else begin
          vec_next   = vec_idx + 4'd1;
          hold_next  = HOLD_LOAD;
          state_next = SETTLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign {a, b, c, d} = vec_idx;

endmodule

// File: tb/tb_nand4_vector_sequencer.sv
// Directed bench for nand4_vector_sequencer: a behavioural NAND cell (or a
// stuck-at fault) drives f_in, and sweep timing/results are checked by hand values.
module tb_nand4_vector_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       start2 = 1'b0;
  int         mode = 0;
  bit         sel = 1'b0;
  int         checks = 0;
  int         errors = 0;

  logic       f_in1, a1, b1, c1, d1, busy1, mismatch1, done1, pass1;
  logic [3:0] vec_idx1;
  logic [4:0] err_count1;
  logic       f_in2, a2, b2, c2, d2, busy2, mismatch2, done2, pass2;
  logic [3:0] vec_idx2;
  logic [4:0] err_count2;

  logic       sel_done, sel_mis;
  logic [3:0] sel_vec, sel_abcd;

  always #5 clk = ~clk;

  // mode 0: healthy NAND cell, 1: output stuck at 1, 2: output stuck at 0
  assign f_in1 = (mode == 0) ? ~(a1 & b1 & c1 & d1) : (mode == 1);
  assign f_in2 = ~(a2 & b2 & c2 & d2);

  assign sel_done = sel ? done2 : done1;
  assign sel_mis  = sel ? mismatch2 : mismatch1;
  assign sel_vec  = sel ? vec_idx2 : vec_idx1;
  assign sel_abcd = sel ? {a2, b2, c2, d2} : {a1, b1, c1, d1};

  nand4_vector_sequencer #(.HOLD_CYCLES(10), .ERR_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .f_in(f_in1),
    .a(a1), .b(b1), .c(c1), .d(d1), .vec_idx(vec_idx1), .busy(busy1),
    .mismatch(mismatch1), .err_count(err_count1), .done(done1), .pass(pass1)
  );

  nand4_vector_sequencer #(.HOLD_CYCLES(1), .ERR_W(5)) dut_short (
    .clk(clk), .rst_n(rst_n), .start(start2), .f_in(f_in2),
    .a(a2), .b(b2), .c(c2), .d(d2), .vec_idx(vec_idx2), .busy(busy2),
    .mismatch(mismatch2), .err_count(err_count2), .done(done2), .pass(pass2)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, observed, expected);
    end
  endtask

  // One-cycle start pulse to the selected DUT; returns at the negedge after the accepting edge.
  task automatic applyStimulus();
    @(negedge clk);
    if (sel) start2 = 1'b1;
    else     start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    start2 = 1'b0;
  endtask

  task automatic runSweep(input int hold, input int repulse_at, output int cycles,
                          output int pulses, output int step_errs, output int mis_cycle);
    bit repulsed;
    repulsed  = 1'b0;
    cycles    = 0;
    pulses    = 0;
    step_errs = 0;
    mis_cycle = -1;
    while (cycles < 1000) begin
      @(negedge clk);
      cycles++;
      start = 1'b0;
      if (sel_mis) begin
        pulses++;
        mis_cycle = cycles;
      end
      if (sel_done) break;
      if (sel_vec != 4'(cycles / (hold + 1))) step_errs++;
      if (sel_abcd != sel_vec) step_errs++;
      if (!repulsed && repulse_at >= 0 && int'(sel_vec) == repulse_at) begin
        start    = 1'b1;
        repulsed = 1'b1;
      end
    end
  endtask

  task automatic checkResetState(input string pfx);
    checkOutput({pfx, "_vec"}, vec_idx1, 0);
    checkOutput({pfx, "_abcd"}, {a1, b1, c1, d1}, 0);
    checkOutput({pfx, "_busy"}, busy1, 0);
    checkOutput({pfx, "_mis"}, mismatch1, 0);
    checkOutput({pfx, "_err"}, err_count1, 0);
    checkOutput({pfx, "_done"}, done1, 0);
    checkOutput({pfx, "_pass"}, pass1, 0);
  endtask

  initial begin
    int cycles, pulses, step_errs, mis_cycle;
    bit found;

    #12;
    checkResetState("rst");
    @(negedge clk) rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Healthy cell, full sweep
    mode = 0;
    applyStimulus();
    checkOutput("start_busy", busy1, 1);
    runSweep(10, -1, cycles, pulses, step_errs, mis_cycle);
    checkOutput("ok_latency", cycles, 176);
    checkOutput("ok_steps", step_errs, 0);
    checkOutput("ok_pulses", pulses, 0);
    checkOutput("ok_err", err_count1, 0);
    checkOutput("ok_pass", pass1, 1);
    checkOutput("ok_busy", busy1, 0);
    checkOutput("ok_vec", vec_idx1, 15);

    // Stuck-at-1: only the all-ones vector fails
    mode = 1;
    applyStimulus();
    checkOutput("rs1_done", done1, 0);
    checkOutput("rs1_err", err_count1, 0);
    runSweep(10, -1, cycles, pulses, step_errs, mis_cycle);
    checkOutput("sa1_latency", cycles, 176);
    checkOutput("sa1_pulses", pulses, 1);
    checkOutput("sa1_pulse_at", mis_cycle, 176);
    checkOutput("sa1_err", err_count1, 1);
    checkOutput("sa1_pass", pass1, 0);

    // Stuck-at-0 started from DONE of a failing sweep
    mode = 2;
    applyStimulus();
    checkOutput("rs2_err", err_count1, 0);
    checkOutput("rs2_done", done1, 0);
    checkOutput("rs2_pass", pass1, 0);
    checkOutput("rs2_busy", busy1, 1);
    runSweep(10, -1, cycles, pulses, step_errs, mis_cycle);
    checkOutput("sa0_steps", step_errs, 0);
    checkOutput("sa0_pulses", pulses, 15);
    checkOutput("sa0_err", err_count1, 15);
    checkOutput("sa0_pass", pass1, 0);
    checkOutput("sa0_done", done1, 1);

    // Reset in the middle of a failing sweep discards the partial count
    applyStimulus();
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk);
      if (vec_idx1 == 4'd7) found = 1'b1;
    end
    checkOutput("mid_reach7", found, 1);
    checkOutput("mid_err", err_count1, 7);
    rst_n = 1'b0;
    #1;
    checkResetState("mid");
    @(negedge clk) rst_n = 1'b1;
    repeat (3) @(negedge clk);
    mode = 0;
    applyStimulus();
    runSweep(10, -1, cycles, pulses, step_errs, mis_cycle);
    checkOutput("post_latency", cycles, 176);
    checkOutput("post_pass", pass1, 1);

    // start while busy must be ignored
    applyStimulus();
    runSweep(10, 3, cycles, pulses, step_errs, mis_cycle);
    checkOutput("busy_latency", cycles, 176);
    checkOutput("busy_steps", step_errs, 0);
    checkOutput("busy_pass", pass1, 1);

    // Shortest hold: two cycles per vector
    sel = 1'b1;
    applyStimulus();
    runSweep(1, -1, cycles, pulses, step_errs, mis_cycle);
    checkOutput("h1_latency", cycles, 32);
    checkOutput("h1_steps", step_errs, 0);
    checkOutput("h1_pass", pass2, 1);
    checkOutput("h1_err", err_count2, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
